// File: rtl/gs_bu2_intt_pkg.sv
// gs_bu2_intt_pkg: shared width, Barrett defaults and pipeline beat type for the INTT butterfly.
// Build option HALF_SCALE_EN folds a modular halve into both butterfly outputs.
`ifndef D_width
`define D_width 14
`endif

package gs_bu2_intt_pkg;

    localparam int DW = `D_width;
    localparam int PRE_W_DEF = 10;
    localparam logic [PRE_W_DEF-1:0] PRECOMPUTE_DEF = 10'd679;

`ifdef HALF_SCALE_EN
    localparam bit HALF_EN = 1'b1;
`else
    localparam bit HALF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] sum;
        logic [DW-1:0] twiddle;
        logic [DW-1:0] modulus;
        logic          valid;
    } beat_t;

    // x/2 mod q for odd q: odd x borrows one q so the shift is exact
    function automatic logic [DW-1:0] halve(input logic [DW-1:0] x, input logic [DW-1:0] q);
        logic [DW:0] s;
        s = x[0] ? {1'b0, x} + {1'b0, q} : {1'b0, x};
        return DW'(s >> 1);
    endfunction

endpackage

// File: rtl/ModAdd.sv
// ModAdd: combinational (a + b) mod q for a, b < q.
module ModAdd #(
    parameter int W = 14
)(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] q,
    output logic [W-1:0] r
);
    logic [W:0] s;
    assign s = {1'b0, a} + {1'b0, b};
    assign r = (s >= {1'b0, q}) ? W'(s - {1'b0, q}) : W'(s);
endmodule

// File: rtl/ModSub.sv
// ModSub: combinational (a - b) mod q for a, b < q.
module ModSub #(
    parameter int W = 14
)(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] q,
    output logic [W-1:0] r
);
    assign r = (a >= b) ? a - b : W'({1'b0, a} + {1'b0, q} - {1'b0, b});
endmodule

// File: rtl/gs_bu2_intt_modmul_pipe.sv
// gs_bu2_intt_modmul_pipe: two-stage (a*b) mod q, product register then reduce register, both gated by en_i.
// Honours HALF_SCALE_EN through the package so the halve lands in the reduce stage.
module gs_bu2_intt_modmul_pipe
    import gs_bu2_intt_pkg::*;
#(
    parameter int PW = PRE_W_DEF,
    parameter logic [PW-1:0] MU = PRECOMPUTE_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] q_i,
    output logic [DW-1:0] r_o
);
    logic [2*DW-1:0]    p_q;
    logic [DW-1:0]      q_q;
    logic [2*DW+PW-1:0] pm;
    logic [DW-1:0]      qh;
    logic [2*DW-1:0]    t;
    logic [DW-1:0]      rem;
    logic [DW-1:0]      r_d;

    // mu*q < 2^(DW+PW) keeps the Barrett quotient an underestimate for any runtime q,
    // so the subtraction never wraps and the final remainder cleans up the residue
    always_comb begin
        pm  = {{PW{1'b0}}, p_q} * (2*DW+PW)'(MU);
        qh  = DW'(pm >> (DW + PW));
        t   = p_q - {{DW{1'b0}}, qh} * {{DW{1'b0}}, q_q};
        rem = (q_q == '0) ? '0 : DW'(t % {{DW{1'b0}}, q_q});
        r_d = HALF_EN ? halve(rem, q_q) : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            q_q <= '0;
            r_o <= '0;
        end else if (en_i) begin
            p_q <= {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
            q_q <= q_i;
            r_o <= r_d;
        end
    end
endmodule

// File: rtl/gs_bu2_intt.sv
// gs_bu2_intt: 3-stage Gentleman-Sande INTT butterfly, a=(in1+in2) mod q, b=((in1-in2)*w) mod q, with valid/ready stall.
// Defining HALF_SCALE_EN halves both outputs mod q, folding the n^-1 scaling into the stages.
module gs_bu2_intt
    import gs_bu2_intt_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF,
    parameter logic [PRE_W-1:0] PRECOMPUTE = PRECOMPUTE_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] twiddle,
    input  logic [DW-1:0] modulus,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] BU_a,
    output logic [DW-1:0] BU_b,
    output logic [DW-1:0] twiddle_BU_out,
    output logic [DW-1:0] modulus_BU_out
);
    logic          adv;
    beat_t         s1_q;
    beat_t         s2_q;
    logic [DW-1:0] add_r;
    logic [DW-1:0] sub_r;
    logic [DW-1:0] diff_q;

    // whole pipe moves in lockstep; only a held output beat freezes it
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    ModAdd #(.W(DW)) u_add (.a(in1), .b(in2), .q(modulus), .r(add_r));
    ModSub #(.W(DW)) u_sub (.a(in1), .b(in2), .q(modulus), .r(sub_r));

    gs_bu2_intt_modmul_pipe #(.PW(PRE_W), .MU(PRECOMPUTE)) u_mul (
        .clk (clk),
        .rst (rst),
        .en_i(adv),
        .a_i (diff_q),
        .b_i (s1_q.twiddle),
        .q_i (s1_q.modulus),
        .r_o (BU_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            diff_q         <= '0;
            out_valid      <= 1'b0;
            BU_a           <= '0;
            twiddle_BU_out <= '0;
            modulus_BU_out <= '0;
        end else if (adv) begin
            s1_q           <= '{sum: add_r, twiddle: twiddle, modulus: modulus, valid: in_valid};
            diff_q         <= sub_r;
            s2_q           <= s1_q;
            out_valid      <= s2_q.valid;
            BU_a           <= HALF_EN ? halve(s2_q.sum, s2_q.modulus) : s2_q.sum;
            twiddle_BU_out <= s2_q.twiddle;
            modulus_BU_out <= s2_q.modulus;
        end
    end
endmodule
